// File: rtl/inst_fetch_if.sv
// Fetch-stage bus bundle: ROM port, execute redirect and decode handshake.
// master is the fetch stage's view; slave is the surrounding ROM/execute/decode side.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef ZeroWord
`define ZeroWord 32'h0000_0000
`endif

interface inst_fetch_if;
    logic                   fetch_en;
    logic [`ADDR_WIDTH-1:0] rom_addr;
    logic [`DATA_WIDTH-1:0] rom_inst;
    logic                   redir_valid;
    logic [`ADDR_WIDTH-1:0] redir_target;
    logic                   out_valid;
    logic                   out_ready;
    logic [`DATA_WIDTH-1:0] out_inst;
    logic [`ADDR_WIDTH-1:0] out_pc;
    logic                   out_exc;

    modport master (
        input  fetch_en,
        input  rom_inst,
        input  redir_valid,
        input  redir_target,
        input  out_ready,
        output rom_addr,
        output out_valid,
        output out_inst,
        output out_pc,
        output out_exc
    );

    modport slave (
        output fetch_en,
        output rom_inst,
        output redir_valid,
        output redir_target,
        output out_ready,
        input  rom_addr,
        input  out_valid,
        input  out_inst,
        input  out_pc,
        input  out_exc
    );
endinterface

// File: rtl/inst_fetch.sv
// Instruction fetch: PC register, combinational ROM access and a 2-entry buffer to decode.
// Define IF_MISALIGN_TRAP_EN to trap on misaligned redirect targets instead of aligning them.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef ZeroWord
`define ZeroWord 32'h0000_0000
`endif

module inst_fetch #(
    parameter logic [`ADDR_WIDTH-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic         CLK,
    input  logic         RST_N,
    inst_fetch_if.master bus
);
    localparam int unsigned AW = `ADDR_WIDTH;
    localparam int unsigned DW = `DATA_WIDTH;

    logic [AW-1:0] pc_q, pc_d;
    logic [AW-1:0] buf_pc_q   [2];
    logic [DW-1:0] buf_inst_q [2];
    logic          rd_ptr_q, rd_ptr_d;
    logic          wr_ptr_q, wr_ptr_d;
    logic [1:0]    count_q, count_d;
    logic          head_valid;
    logic          pop;
    logic          push;
    logic [AW-1:0] redir_pc;

`ifdef IF_MISALIGN_TRAP_EN
    logic          halted_exc_q, halted_exc_d;
    logic          push_exc;
    logic          buf_exc_q [2];

    assign push_exc = pc_q[1:0] != 2'b00;
    assign redir_pc = bus.redir_target;
`else
    logic          halted_exc_q;

    assign halted_exc_q = 1'b0;
    assign redir_pc     = bus.redir_target & {{(AW-2){1'b1}}, 2'b00};
`endif

    assign head_valid = count_q != 2'd0;
    // A handshake coinciding with a redirect is dropped; decode discards it on its side.
    assign pop  = head_valid && bus.out_ready && !bus.redir_valid;
    assign push = bus.fetch_en && !bus.redir_valid && !halted_exc_q &&
                  (count_q != 2'd2 || pop);

    always_comb begin
        pc_d     = pc_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (bus.redir_valid) begin
            pc_d     = redir_pc;
            rd_ptr_d = 1'b0;
            wr_ptr_d = 1'b0;
            count_d  = 2'd0;
        end else begin
            if (push) begin
                pc_d     = pc_q + AW'(4);
                wr_ptr_d = ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + 2'd1;
                2'b01:   count_d = count_q - 2'd1;
                default: count_d = count_q;
            endcase
        end
    end

`ifdef IF_MISALIGN_TRAP_EN
    always_comb begin
        halted_exc_d = halted_exc_q;
        if (bus.redir_valid) begin
            halted_exc_d = 1'b0;
        end else if (push && push_exc) begin
            halted_exc_d = 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            halted_exc_q <= 1'b0;
            buf_exc_q[0] <= 1'b0;
            buf_exc_q[1] <= 1'b0;
        end else begin
            halted_exc_q <= halted_exc_d;
            if (push) begin
                buf_exc_q[wr_ptr_q] <= push_exc;
            end
        end
    end
`endif

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            pc_q     <= RESET_PC;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            pc_q     <= pc_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < 2; i++) begin
                buf_pc_q[i]   <= '0;
                buf_inst_q[i] <= `ZeroWord;
            end
        end else if (push) begin
            buf_pc_q[wr_ptr_q] <= pc_q;
`ifdef IF_MISALIGN_TRAP_EN
            // A trapping entry carries no instruction bits.
            buf_inst_q[wr_ptr_q] <= push_exc ? `ZeroWord : bus.rom_inst;
`else
            buf_inst_q[wr_ptr_q] <= bus.rom_inst;
`endif
        end
    end

    always_comb begin
        bus.rom_addr  = pc_q;
        bus.out_valid = head_valid;
        bus.out_pc    = head_valid ? buf_pc_q[rd_ptr_q] : '0;
        bus.out_inst  = head_valid ? buf_inst_q[rd_ptr_q] : `ZeroWord;
`ifdef IF_MISALIGN_TRAP_EN
        bus.out_exc   = head_valid ? buf_exc_q[rd_ptr_q] : 1'b0;
`else
        bus.out_exc   = 1'b0;
`endif
    end

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: directed vectors, a queue-based reference model checked every cycle,
// and literal expectations at the key points of each scenario.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef ZeroWord
`define ZeroWord 32'h0000_0000
`endif

module tb_inst_fetch;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        exc;
    } ent_t;

    logic CLK = 1'b0;
    logic RST_N;
    int   errors = 0;
    int   checks = 0;

    inst_fetch_if bus ();

    inst_fetch #(.RESET_PC(RESET_PC)) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    // ROM: word n holds n.
    function automatic logic [31:0] rom_word(input logic [31:0] addr);
        return addr >> 2;
    endfunction

    assign bus.rom_inst = rom_word(bus.rom_addr);

    // Reference model state.
    ent_t        mq[$];
    logic [31:0] m_pc   = RESET_PC;
    bit          m_halt = 1'b0;
    int          m_n;
    bit          m_pop;
    bit          m_push;
    ent_t        m_e;

    initial begin
        forever begin
            @(posedge CLK or negedge RST_N);
            if (!RST_N) begin
                mq.delete();
                m_pc   = RESET_PC;
                m_halt = 1'b0;
            end else if (bus.redir_valid) begin
                mq.delete();
`ifdef IF_MISALIGN_TRAP_EN
                m_pc = bus.redir_target;
`else
                m_pc = {bus.redir_target[31:2], 2'b00};
`endif
                m_halt = 1'b0;
            end else begin
                m_n    = mq.size();
                m_pop  = (m_n != 0) && bus.out_ready;
                m_push = bus.fetch_en && !m_halt && (m_n < 2 || m_pop);
                if (m_pop) void'(mq.pop_front());
                if (m_push) begin
                    m_e.pc = m_pc;
                    if (m_pc % 4 != 0) begin
                        m_e.inst = 32'd0;
                        m_e.exc  = 1'b1;
                        m_halt   = 1'b1;
                    end else begin
                        m_e.inst = rom_word(m_pc);
                        m_e.exc  = 1'b0;
                    end
                    mq.push_back(m_e);
                    m_pc = m_pc + 32'd4;
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Compare DUT outputs against the model away from the active edge.
    always @(negedge CLK) begin
        if (mq.size() != 0) begin
            check("model out_valid", 32'(bus.out_valid), 32'd1);
            check("model out_pc", bus.out_pc, mq[0].pc);
            check("model out_inst", bus.out_inst, mq[0].inst);
            check("model out_exc", 32'(bus.out_exc), 32'(mq[0].exc));
        end else begin
            check("model out_valid", 32'(bus.out_valid), 32'd0);
            check("model idle out_pc", bus.out_pc, 32'd0);
            check("model idle out_inst", bus.out_inst, `ZeroWord);
            check("model idle out_exc", 32'(bus.out_exc), 32'd0);
        end
        check("model rom_addr", bus.rom_addr, m_pc);
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic redirect(input logic [31:0] target);
        bus.redir_valid  = 1'b1;
        bus.redir_target = target;
        step();
        bus.redir_valid  = 1'b0;
    endtask

    initial begin
        RST_N            = 1'b0;
        bus.fetch_en     = 1'b1;
        bus.out_ready    = 1'b1;
        bus.redir_valid  = 1'b0;
        bus.redir_target = 32'd0;
        step();
        step();
        check("reset out_valid", 32'(bus.out_valid), 32'd0);
        check("reset rom_addr", bus.rom_addr, RESET_PC);

        // Streaming from reset: 0,4,8,12 with inst 0,1,2,3, no gaps.
        RST_N = 1'b1;
        check("first rom_addr", bus.rom_addr, 32'h0);
        check("first out_valid", 32'(bus.out_valid), 32'd0);
        for (int i = 0; i < 4; i++) begin
            step();
            check("stream out_valid", 32'(bus.out_valid), 32'd1);
            check("stream out_pc", bus.out_pc, 32'(4 * i));
            check("stream out_inst", bus.out_inst, 32'(i));
        end

        // Mid-stream reset drops everything at once.
        RST_N = 1'b0;
        #1;
        check("async reset out_valid", 32'(bus.out_valid), 32'd0);
        check("async reset rom_addr", bus.rom_addr, RESET_PC);
        check("async reset out_pc", bus.out_pc, 32'd0);

        // Backpressure: buffer fills, pc holds at 8, then resumes without a bubble.
        bus.out_ready = 1'b0;
        step();
        RST_N = 1'b1;
        for (int i = 0; i < 5; i++) step();
        check("stall rom_addr", bus.rom_addr, 32'h8);
        check("stall out_pc", bus.out_pc, 32'h0);
        check("stall out_valid", 32'(bus.out_valid), 32'd1);
        bus.out_ready = 1'b1;
        step();
        check("resume out_pc 4", bus.out_pc, 32'h4);
        step();
        check("resume out_pc 8", bus.out_pc, 32'h8);
        step();
        check("resume out_pc 12", bus.out_pc, 32'hC);

        // Redirect with two entries buffered.
        bus.out_ready = 1'b0;
        step();
        step();
        bus.out_ready = 1'b1;
        redirect(32'h100);
        check("redir bubble", 32'(bus.out_valid), 32'd0);
        step();
        check("redir target pc", bus.out_pc, 32'h100);
        check("redir target inst", bus.out_inst, 32'h40);
        step();
        check("redir next pc", bus.out_pc, 32'h104);

        // fetch_en pulse low: drain, then resume at the held pc.
        bus.fetch_en = 1'b0;
        step();
        check("halt drained", 32'(bus.out_valid), 32'd0);
        step();
        step();
        check("halt out_valid", 32'(bus.out_valid), 32'd0);
        check("halt rom_addr", bus.rom_addr, 32'h108);
        bus.fetch_en = 1'b1;
        step();
        check("halt resume pc", bus.out_pc, 32'h108);

        // PC wrap.
        redirect(32'hFFFF_FFF8);
        step();
        check("wrap pc 0", bus.out_pc, 32'hFFFF_FFF8);
        step();
        check("wrap pc 1", bus.out_pc, 32'hFFFF_FFFC);
        step();
        check("wrap pc 2", bus.out_pc, 32'h0000_0000);

        // Misaligned redirect.
        redirect(32'h102);
        step();
`ifdef IF_MISALIGN_TRAP_EN
        check("trap out_pc", bus.out_pc, 32'h102);
        check("trap out_exc", 32'(bus.out_exc), 32'd1);
        check("trap out_inst", bus.out_inst, 32'd0);
        for (int i = 0; i < 4; i++) begin
            step();
            check("trap halted", 32'(bus.out_valid), 32'd0);
        end
        redirect(32'h200);
        step();
        check("trap cleared pc", bus.out_pc, 32'h200);
        check("trap cleared exc", 32'(bus.out_exc), 32'd0);
`else
        check("align out_pc", bus.out_pc, 32'h100);
        check("align out_exc", 32'(bus.out_exc), 32'd0);
        check("align out_inst", bus.out_inst, 32'h40);
`endif

        // Mixed directed pattern, checked by the model every cycle.
        for (int i = 0; i < 48; i++) begin
            bus.out_ready   = (i % 3) != 0;
            bus.fetch_en    = (i % 5) != 4;
            bus.redir_valid = (i == 20) || (i == 33) || (i == 41);
            bus.redir_target = (i == 20) ? 32'h3C8 : (i == 33) ? 32'h2E : 32'h80;
            step();
        end
        bus.redir_valid = 1'b0;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
